shift_add_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier, successor to the 8-bit switch-driven multiplier. It multiplies two WIDTH-bit operands, signed (two's complement) or unsigned, selected per operation. It processes one multiplier bit per clock, with the add and the shift merged into one cycle. It sits behind a Start/Busy/Done handshake so a controller or top-level wrapper can issue operations back to back and read a full 2·WIDTH-bit product.

---
 rtl/shift_add_multiplier.sv | 124 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, with the add and the shift in the same cycle.
// In signed mode the multiplier sign bit carries weight -2^(WIDTH-1), so the last step subtracts.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for Start; Product holds the last result
// ST_CALC | one add/shift step per clock, WIDTH steps in total
// ST_DONE | one-cycle Done pulse; Product is final
module shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Signed_Mode,
   input  logic [WIDTH-1:0]   Mcand,
   input  logic [WIDTH-1:0]   Mplier,
   output logic               Busy,
   output logic               Done,
   output logic [2*WIDTH-1:0] Product,
   output logic               Xval
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH:0]   ONE_EXT  = (WIDTH + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             x_q, x_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s_q, s_d;

   logic [WIDTH-1:0] t_op;
   logic [WIDTH:0]   a_ext;
   logic [WIDTH:0]   t_ext;
   logic [WIDTH:0]   sum;
   logic             sub;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         m_q     <= '0;
         a_q     <= '0;
         q_q     <= '0;
         x_q     <= 1'b0;
         cnt_q   <= '0;
         s_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         a_q     <= a_d;
         q_q     <= q_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
      end
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      a_d     = a_q;
      q_d     = q_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      t_op    = '0;
      a_ext   = '0;
      t_ext   = '0;
      sum     = '0;
      sub     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               m_d     = Mcand;
               q_d     = Mplier;
               a_d     = '0;
               x_d     = 1'b0;
               cnt_d   = '0;
               s_d     = Signed_Mode;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            t_op  = q_q[0] ? m_q : '0;
            sub   = s_q && (cnt_q == CNT_LAST);
            // One extra adder bit keeps the true sign (signed) or the carry (unsigned).
            a_ext = {s_q & a_q[WIDTH-1], a_q};
            t_ext = {s_q & t_op[WIDTH-1], t_op};
            sum   = sub ? (a_ext + ~t_ext + ONE_EXT) : (a_ext + t_ext);
            x_d   = sum[WIDTH];
            a_d   = {sum[WIDTH], sum[WIDTH-1:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign Busy    = (state_q != ST_IDLE);
   assign Done    = (state_q == ST_DONE);
   assign Product = {a_q, q_q};
   assign Xval    = x_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: 8-bit instance checked every cycle against an arithmetic model,
// plus directed boundary cases and a 16-bit instance.
module tb_shift_add_multiplier;

   localparam int W = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        smode = 1'b0;
   logic [7:0]  mcand = '0;
   logic [7:0]  mplier = '0;
   logic        busy, done, xval;
   logic [15:0] product;

   logic        s16_start = 1'b0;
   logic        s16_smode = 1'b0;
   logic [15:0] s16_mcand = '0;
   logic [15:0] s16_mplier = '0;
   logic        s16_busy, s16_done, s16_xval;
   logic [31:0] s16_product;

   int n_vec = 0;
   int n_err = 0;

   // expectation model: operation phase and the product the outputs must show
   int          phase = 0;
   logic [15:0] exp_prod = '0;
   logic [15:0] fin_prod = '0;
   logic        exp_x = 1'b0;

   shift_add_multiplier #(.WIDTH(8)) dut8 (
      .Clk(clk), .Reset(rst), .Start(start), .Signed_Mode(smode),
      .Mcand(mcand), .Mplier(mplier), .Busy(busy), .Done(done),
      .Product(product), .Xval(xval)
   );

   shift_add_multiplier #(.WIDTH(16)) dut16 (
      .Clk(clk), .Reset(rst), .Start(s16_start), .Signed_Mode(s16_smode),
      .Mcand(s16_mcand), .Mplier(s16_mplier), .Busy(s16_busy), .Done(s16_done),
      .Product(s16_product), .Xval(s16_xval)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_mul(input logic sm, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
      longint pa, pb;
      logic [63:0] p;
      pa = longint'({32'h0, a});
      pb = longint'({32'h0, b});
      if (sm && a[w-1]) pa = pa - (longint'(1) <<< w);
      if (sm && b[w-1]) pb = pb - (longint'(1) <<< w);
      p = 64'(pa * pb);
      return p & ((64'h1 << (2 * w)) - 64'h1);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         phase    <= 0;
         exp_prod <= '0;
         exp_x    <= 1'b0;
      end else if (phase == 0) begin
         if (start) begin
            phase    <= 1;
            exp_prod <= {8'h00, mplier};
            exp_x    <= 1'b0;
            fin_prod <= 16'(ref_mul(smode, {24'h0, mcand}, {24'h0, mplier}, W));
         end
      end else if (phase == W) begin
         phase    <= W + 1;
         exp_prod <= fin_prod;
         exp_x    <= fin_prod[15];
      end else if (phase == W + 1) begin
         phase <= 0;
      end else begin
         phase <= phase + 1;
      end
   end

   always @(posedge clk) begin
      #1;
      check("busy", {63'h0, busy}, {63'h0, phase != 0});
      check("done", {63'h0, done}, {63'h0, phase == W + 1});
      if (phase == 0 || phase == 1 || phase == W + 1) begin
         check("product", {48'h0, product}, {48'h0, exp_prod});
         check("xval", {63'h0, xval}, {63'h0, exp_x});
      end
   end

   task automatic run_op(input logic sm, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] lit, input string name);
      int cyc;
      int busy_n;
      check({name, "_model"}, ref_mul(sm, {24'h0, a}, {24'h0, b}, W), {48'h0, lit});
      @(posedge clk); #2;
      start = 1'b1; smode = sm; mcand = a; mplier = b;
      @(posedge clk); #2;
      start = 1'b0; smode = ~sm; mcand = ~a; mplier = ~b;
      busy_n = busy ? 1 : 0;
      cyc = 0;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (busy) busy_n++;
      end
      check({name, "_latency"}, 64'(cyc), 64'(W));
      check({name, "_product"}, {48'h0, product}, {48'h0, lit});
      check({name, "_busy_cycles"}, 64'(busy_n), 64'(W + 1));
      @(posedge clk); #1;
      check({name, "_idle_after"}, {62'h0, busy, done}, 64'h0);
      check({name, "_held"}, {48'h0, product}, {48'h0, lit});
   endtask

   task automatic run_op16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] lit, input string name);
      int cyc;
      check({name, "_model"}, ref_mul(sm, {16'h0, a}, {16'h0, b}, 16), {32'h0, lit});
      @(posedge clk); #2;
      s16_start = 1'b1; s16_smode = sm; s16_mcand = a; s16_mplier = b;
      @(posedge clk); #2;
      s16_start = 1'b0; s16_mcand = '0; s16_mplier = '0;
      cyc = 0;
      while (!s16_done && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({name, "_latency"}, 64'(cyc), 64'd16);
      check({name, "_product"}, {32'h0, s16_product}, {32'h0, lit});
      @(posedge clk); #1;
      check({name, "_idle_after"}, {62'h0, s16_busy, s16_done}, 64'h0);
   endtask

   initial begin
      int last;
      int ndone;
      logic [7:0] pool [5];
      pool[0] = 8'h80; pool[1] = 8'h7F; pool[2] = 8'hFF; pool[3] = 8'h00; pool[4] = 8'h01;

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {46'h0, busy, done, product}, 64'h0);
      check("reset_xval", {63'h0, xval}, 64'h0);
      #1;
      rst = 1'b0;

      run_op(1'b1, 8'hF9, 8'h03, 16'hFFEB, "s_f9x03");
      run_op(1'b1, 8'h80, 8'h80, 16'h4000, "s_80x80");
      run_op(1'b1, 8'h80, 8'h7F, 16'hC080, "s_80x7f");
      run_op(1'b1, 8'h7F, 8'h80, 16'hC080, "s_7fx80");
      run_op(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ffxff");
      run_op(1'b1, 8'hFF, 8'hFF, 16'h0001, "s_ffxff");
      run_op(1'b0, 8'hA5, 8'h00, 16'h0000, "u_mplier0");
      run_op(1'b1, 8'h80, 8'h00, 16'h0000, "s_mplier0");

      // Start held high with operands moving every cycle
      @(posedge clk); #2;
      start = 1'b1;
      last = -1;
      ndone = 0;
      for (int i = 0; i < 65; i++) begin
         @(posedge clk); #1;
         if (done) begin
            if (last >= 0) check("start_spacing", 64'(i - last), 64'd10);
            last = i;
            ndone++;
         end
         #1;
         mcand = 8'($urandom);
         mplier = 8'($urandom);
         smode = 1'($urandom);
      end
      start = 1'b0;
      check("held_done_count", 64'(ndone), 64'd6);
      repeat (12) @(posedge clk);

      // reset during the 4th calculation cycle aborts the operation
      #2;
      start = 1'b1; smode = 1'b1; mcand = 8'hF9; mplier = 8'h03;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_outputs", {46'h0, busy, done, product}, 64'h0);
      check("abort_xval", {63'h0, xval}, 64'h0);
      #1;
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      check("abort_no_done", 64'(ndone), 64'd0);
      run_op(1'b0, 8'h05, 8'h06, 16'h001E, "u_05x06");

      // randomized traffic including mid-operation resets and Start/Reset collisions
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #2;
         start  = ($urandom % 3) != 0;
         rst    = ($urandom % 60) == 0;
         smode  = 1'($urandom);
         mcand  = ($urandom % 4 == 0) ? pool[$urandom % 5] : 8'($urandom);
         mplier = ($urandom % 4 == 0) ? pool[$urandom % 5] : 8'($urandom);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      start = 1'b0;
      repeat (12) @(posedge clk);

      run_op16(1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, "w16_s_ffff");
      run_op16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "w16_u_ffff");
      run_op16(1'b1, 16'h8000, 16'h8000, 32'h40000000, "w16_s_8000");

      @(posedge clk); #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
